// File: rtl/cycle_sequencer_pkg.sv
// cycle_sequencer_pkg
//   Shared decode-interface definitions for the M6502 sequencing block.
//   Holds the enable-bus indices used by DecodeLogic and the sequencer,
//   the T0..T7 bit positions of the one-hot timing vector, and the
//   one-hot cycle-state enumeration.
package cycle_sequencer_pkg;

    // Enable-bus indices (bit positions within the 64-bit enables bus)
    localparam int TIMING_RESET = 0;
    localparam int WRITE_EN     = 1;
    localparam int PC_INC       = 2;
    localparam int RA_DATA_IN_Q = 3;
    localparam int PC_LOAD      = 4;

    // Bit positions of the timing vector: bit n = Tn
    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;
    localparam int T5 = 5;
    localparam int T6 = 6;
    localparam int T7 = 7;

    // Opcode held after reset: NOP decodes harmlessly
    localparam logic [7:0] OPC_NOP = 8'hEA;

    // One-hot cycle states; the encoding is the timing vector itself
    typedef enum logic [7:0] {
        ST_T0 = 8'h01,
        ST_T1 = 8'h02,
        ST_T2 = 8'h04,
        ST_T3 = 8'h08,
        ST_T4 = 8'h10,
        ST_T5 = 8'h20,
        ST_T6 = 8'h40,
        ST_T7 = 8'h80
    } timing_t;

endpackage

// File: rtl/cycle_sequencer_program_counter.sv
// program_counter
//   16-bit program counter with synchronous active-high reset to RESET_PC.
//   Load has priority over increment; increment wraps modulo 2^16.
// Ports:
//   clock      - system clock
//   reset      - synchronous active-high reset
//   load       - load pc from load_value
//   inc        - increment pc by one
//   load_value - value loaded when load is set
//   pc         - current program counter
module program_counter #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        inc,
    input  logic [15:0] load_value,
    output logic [15:0] pc
);

    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + 16'd1;
        end
    end

endmodule

// File: rtl/cycle_sequencer.sv
// cycle_sequencer
//   Sequencing end of the M6502 decode interface. Generates the one-hot
//   timing vector and the registered opcode consumed by DecodeLogic, and
//   owns the program counter, opcode fetch register and operand-low latch.
// Ports:
//   clock   - system clock, all state updates on rising edge
//   reset   - synchronous active-high reset
//   data_in - memory read data for the current address
//   enables - control enables from DecodeLogic (TIMING_RESET, PC_INC, PC_LOAD)
//   timing  - one-hot cycle state T0..T7, bit n = Tn
//   opcode  - instruction register
//   address - memory address, equal to the program counter
//   overrun - sticky: timing wrapped past T7 without TIMING_RESET
module cycle_sequencer
    import cycle_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic [63:0] enables,
    output logic [7:0]  timing,
    output logic [7:0]  opcode,
    output logic [15:0] address,
    output logic        overrun
);

    timing_t     state;
    logic [7:0]  adl;
    logic        pc_load;
    logic        pc_inc;
    logic [15:0] pc;

    // WRITE_EN and the remaining enables are decoded elsewhere
    logic unused_enables;
    assign unused_enables = ^enables;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_T0;
            opcode  <= OPC_NOP;
            adl     <= 8'h00;
            overrun <= 1'b0;
        end else begin
            // TIMING_RESET is ignored in T0: the decoder is still looking
            // at the previous instruction's opcode during the fetch cycle.
            if (state == ST_T0) begin
                state <= ST_T1;
            end else if (enables[TIMING_RESET]) begin
                state <= ST_T0;
            end else begin
                case (state)
                    ST_T1:   state <= ST_T2;
                    ST_T2:   state <= ST_T3;
                    ST_T3:   state <= ST_T4;
                    ST_T4:   state <= ST_T5;
                    ST_T5:   state <= ST_T6;
                    ST_T6:   state <= ST_T7;
                    ST_T7: begin
                        state   <= ST_T0;
                        overrun <= 1'b1;
                    end
                    default: state <= ST_T0;
                endcase
            end

            if (state == ST_T0) begin
                opcode <= data_in;
            end
            if (state == ST_T1) begin
                adl <= data_in;
            end
        end
    end

    // Fetch cycle always increments; a PC_INC in the same cycle merges
    // into that single increment. A stale PC_LOAD during T0 is ignored.
    assign pc_load = enables[PC_LOAD] && !state[T0];
    assign pc_inc  = state[T0] || enables[PC_INC];

    program_counter #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clock      (clock),
        .reset      (reset),
        .load       (pc_load),
        .inc        (pc_inc),
        .load_value ({data_in, adl}),
        .pc         (pc)
    );

    assign timing  = state;
    assign address = pc;

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer
//   Bench for cycle_sequencer: a memory array feeds data_in, a small
//   instruction-level decoder drives enables, a cycle-level model tracks
//   the expected timing/opcode/address/overrun, and directed literal
//   expectations pin both the model and the DUT at chosen cycles.
module tb_cycle_sequencer;
    import cycle_sequencer_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        rst_w;
    logic [7:0]  data_in;
    logic [7:0]  data_in_w;
    logic [63:0] enables;
    logic [63:0] enables_w;
    logic [7:0]  timing, timing_w;
    logic [7:0]  opcode, opcode_w;
    logic [15:0] address, address_w;
    logic        overrun, overrun_w;

    logic [7:0] mem [0:65535];
    logic       force_a9;
    logic       dec_on;

    assign data_in   = force_a9 ? 8'hA9 : mem[address];
    assign data_in_w = 8'hEA;
    // Wrap instance: NOP stream with PC_INC and TIMING_RESET held high
    assign enables_w = (64'd1 << TIMING_RESET) | (64'd1 << PC_INC);

    cycle_sequencer dut (
        .clock   (clock),
        .reset   (reset),
        .data_in (data_in),
        .enables (enables),
        .timing  (timing),
        .opcode  (opcode),
        .address (address),
        .overrun (overrun)
    );

    cycle_sequencer #(
        .RESET_PC(16'hFFFF)
    ) dut_w (
        .clock   (clock),
        .reset   (rst_w),
        .data_in (data_in_w),
        .enables (enables_w),
        .timing  (timing_w),
        .opcode  (opcode_w),
        .address (address_w),
        .overrun (overrun_w)
    );

    // ---------------- behavioural model ----------------
    int          m_t;      // current cycle number 0..7
    logic [15:0] m_pc;
    logic [7:0]  m_op;
    logic [7:0]  m_adl;
    logic        m_ovr;

    always @(posedge clock) begin : model
        logic [7:0] d;
        d = mem[m_pc];
        if (reset) begin
            m_t   <= 0;
            m_pc  <= 16'h0000;
            m_op  <= 8'hEA;
            m_adl <= 8'h00;
            m_ovr <= 1'b0;
        end else begin
            if (enables[PC_LOAD] && m_t != 0)
                m_pc <= {d, m_adl};
            else if (m_t == 0 || enables[PC_INC])
                m_pc <= m_pc + 16'd1;
            if (m_t == 0) m_op  <= d;
            if (m_t == 1) m_adl <= d;
            if (m_t == 0)
                m_t <= 1;
            else if (enables[TIMING_RESET])
                m_t <= 0;
            else if (m_t == 7) begin
                m_t   <= 0;
                m_ovr <= 1'b1;
            end else
                m_t <= m_t + 1;
        end
    end

    // Instruction-level decoder: NOP/LDA# finish at T1, JMP abs loads at T2.
    // Stale enables during T0 exercise the fetch-cycle ignore rules.
    always @* begin
        enables = '0;
        if (dec_on) begin
            case (m_op)
                8'hEA: if (m_t <= 1)
                    enables = (64'd1 << TIMING_RESET) | (64'd1 << PC_INC);
                8'hA9: if (m_t == 1)
                    enables = (64'd1 << TIMING_RESET) | (64'd1 << PC_INC);
                8'h4C: begin
                    if (m_t == 1)
                        enables = (64'd1 << PC_INC);
                    else if (m_t == 2 || m_t == 0)
                        enables = (64'd1 << PC_LOAD) | (64'd1 << TIMING_RESET);
                end
                default: if (m_t == 1)
                    enables = (64'd1 << TIMING_RESET);
            endcase
        end
    end

    // ---------------- checking ----------------
    int n_asserts = 0;
    int n_fail    = 0;
    bit started   = 1'b0;
    int lit_id    = 0;
    int lit_seen  = 0;

    logic [7:0]  l_tim, l_op;
    logic [15:0] l_addr, l_addrw;
    logic        l_ovr;
    bit          l_chk_op, l_chk_w;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin : compare
        logic [7:0] e_t;
        if (started) begin
            e_t = 8'd1 << m_t;
            check("model timing",  {8'h00, timing}, {8'h00, e_t});
            check("model opcode",  {8'h00, opcode}, {8'h00, m_op});
            check("model address", address, m_pc);
            check("model overrun", {15'h0, overrun}, {15'h0, m_ovr});
            if (lit_id != lit_seen) begin
                lit_seen = lit_id;
                check("lit timing",  {8'h00, timing}, {8'h00, l_tim});
                check("lit address", address, l_addr);
                check("lit overrun", {15'h0, overrun}, {15'h0, l_ovr});
                if (l_chk_op) check("lit opcode", {8'h00, opcode}, {8'h00, l_op});
                if (l_chk_w)  check("lit wrap address", address_w, l_addrw);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic lit(input logic [7:0] t, input logic [7:0] op, input bit cop,
                       input logic [15:0] a, input logic ov,
                       input bit cw, input logic [15:0] aw);
        l_tim    = t;
        l_op     = op;
        l_chk_op = cop;
        l_addr   = a;
        l_ovr    = ov;
        l_chk_w  = cw;
        l_addrw  = aw;
        lit_id++;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        reset    = 1'b1;
        rst_w    = 1'b1;
        force_a9 = 1'b1;
        dec_on   = 1'b1;

        // Reset held two cycles with data_in = A9
        tick();
        tick();
        started = 1'b1;
        lit(8'h01, 8'hEA, 1, 16'h0000, 1'b0, 1, 16'hFFFF);

        // NOP stream; wrap instance goes FFFF -> 0000 -> 0001 -> 0002
        reset    = 1'b0;
        rst_w    = 1'b0;
        force_a9 = 1'b0;
        tick(); lit(8'h02, 8'hEA, 1, 16'h0001, 1'b0, 1, 16'h0000);
        tick(); lit(8'h01, 8'hEA, 1, 16'h0002, 1'b0, 1, 16'h0001);
        tick(); lit(8'h02, 8'hEA, 1, 16'h0003, 1'b0, 1, 16'h0002);
        tick(); lit(8'h01, 8'hEA, 1, 16'h0004, 1'b0, 1, 16'h0003);

        // JMP $1234 followed by LDA #$05
        mem[16'h0000] = 8'h4C;
        mem[16'h0001] = 8'h34;
        mem[16'h0002] = 8'h12;
        mem[16'h1234] = 8'hA9;
        mem[16'h1235] = 8'h05;
        reset = 1'b1;
        tick(); lit(8'h01, 8'hEA, 1, 16'h0000, 1'b0, 0, 16'h0000);
        reset = 1'b0;
        tick(); lit(8'h02, 8'h4C, 1, 16'h0001, 1'b0, 0, 16'h0000);
        tick(); lit(8'h04, 8'h4C, 1, 16'h0002, 1'b0, 0, 16'h0000);
        tick(); lit(8'h01, 8'h4C, 1, 16'h1234, 1'b0, 0, 16'h0000);
        tick(); lit(8'h02, 8'hA9, 1, 16'h1235, 1'b0, 0, 16'h0000);
        tick(); lit(8'h01, 8'hA9, 1, 16'h1236, 1'b0, 0, 16'h0000);
        tick(); lit(8'h02, 8'hEA, 1, 16'h1237, 1'b0, 0, 16'h0000);

        // Reset at T2 of JMP while PC_LOAD is high: no load applied
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(); lit(8'h02, 8'h4C, 1, 16'h0001, 1'b0, 0, 16'h0000);
        tick(); lit(8'h04, 8'h4C, 1, 16'h0002, 1'b0, 0, 16'h0000);
        reset = 1'b1;
        tick(); lit(8'h01, 8'hEA, 1, 16'h0000, 1'b0, 0, 16'h0000);

        // Overrun: no enables after the fetch, ring walks T0..T7 and wraps
        reset  = 1'b0;
        dec_on = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            lit(8'd1 << (i % 8), (i < 9) ? 8'h4C : 8'h34, 1,
                (i < 9) ? 16'h0001 : 16'h0002, (i >= 8), 0, 16'h0000);
        end

        // Reset clears the sticky overrun
        reset = 1'b1;
        tick(); lit(8'h01, 8'hEA, 1, 16'h0000, 1'b0, 0, 16'h0000);
        reset = 1'b0;
        tick(); lit(8'h02, 8'h4C, 1, 16'h0001, 1'b0, 0, 16'h0000);
        tick();

        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
- Sequencing end of the M6502 decode interface.
- Generates the one-hot `timing` vector and the registered `opcode` that DecodeLogic consumes.
- Consumes DecodeLogic's `enables` bus: TIMING_RESET, PC_INC, PC_LOAD.
- Owns the 16-bit program counter, the opcode fetch register and the operand-low latch; drives the memory address.

Parameters:
- RESET_PC, 16'h0000, program counter value loaded on reset.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  memory read data for the current address.
- enables  input  64  control enables from DecodeLogic; indexed by shared defines.
- timing  output  8  one-hot cycle state T0..T7; bit n = Tn.
- opcode  output  8  instruction register.
- address  output  16  memory address; equals pc.
- overrun  output  1  sticky flag: timing wrapped past T7 without TIMING_RESET.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clock and reset.
- Reset (sampled at rising edge) overrides everything, including mid-instruction:
  - timing <= 8'b0000_0001 (T0).
  - opcode <= 8'hEA (NOP, benign decode).
  - pc <= RESET_PC.
  - adl <= 8'h00.
  - overrun <= 0.
- Timing ring, evaluated in priority order each non-reset edge:
  - If timing[0]: always advance to T1. TIMING_RESET is ignored in T0, because the opcode register still holds the previous instruction.
  - Else if enables[`TIMING_RESET]: timing <= T0.
  - Else if timing[7]: timing <= T0 and overrun <= 1. overrun stays set until reset.
  - Else: timing <= timing << 1.
- Opcode fetch: when timing[0], opcode <= data_in. It is therefore valid to the decoder from T1 onward. opcode holds in all other cycles.
- Operand-low latch: when timing[1], adl <= data_in. adl is internal.
- Program counter, in priority order:
  - If enables[`PC_LOAD] and not timing[0]: pc <= {data_in, adl}.
  - Else if timing[0] or enables[`PC_INC]: pc <= pc + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000). PC_INC asserted together with the T0 fetch increments once, not twice.
  - Else pc holds.
- address = pc, combinational from the register; zero extra latency.
- Resulting instruction lengths with the current decoder:
  - NOP: 2 cycles (T0, T1).
  - LDA #imm: 2 cycles (T0, T1; operand read at T1).
  - JMP abs: 3 cycles (T0, T1, T2; load at T2).
- The timing vector is always exactly one-hot. No illegal state is reachable.
- WRITE_EN is ignored by this block.

Decomposition:
- Shared define header (already included by DecodeLogic) holds the enable indices: `TIMING_RESET, `WRITE_EN, `PC_INC, `RA_DATA_IN_Q.
- Add a new `PC_LOAD index to that header.
- T0..T7 bit-position defines go in the same header.
- One natural sub-module, program_counter: 16-bit register with load/increment priority and RESET_PC parameter. The timing ring and the opcode/adl registers stay in cycle_sequencer.

Test Plan:
- Reset: hold reset 2 cycles with data_in=8'hA9 -> timing=8'h01, opcode=8'hEA, address=16'h0000, overrun=0.
- NOP stream: memory all 8'hEA from 0 -> timing alternates 8'h01, 8'h02; opcode=8'hEA from T1; address 0, 1, 2, 3 (+1 per cycle).
- JMP: mem[0..2]=4C 34 12 -> T0 addr 0000, T1 addr 0001 (adl=34), T2 addr 0002 with PC_LOAD -> next cycle T0, address=16'h1234.
- Wrap: RESET_PC=16'hFFFF, NOP stream -> address FFFF then 0000.
- Overrun: enables tied to 0 after fetch -> timing walks 01..80, then 01 with overrun=1; overrun stays 1 until reset, then clears.
- Reset mid-instruction: assert reset at T2 of a JMP with PC_LOAD high -> next cycle timing=8'h01, address=RESET_PC, with no load applied.
